execute_muldiv: RTL
===================

EXECUTE_MULDIV -- requirements
Module: execute_muldiv

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1: reset is synchronous and active-high.
REQ-003 SHALL have port decode_i_alu_info, input, 28, the ALU one-hot from decode. Bits 12..0 are mul, mulh, mulhsu, mulhu, div, divu, rem, remu, mulw, divw, divuw, remw, remuw, MSB to LSB. Bits 27..13 are ignored.
REQ-004 SHALL have port muldiv_i_valid, input, 1, operation request.
REQ-005 SHALL have port muldiv_o_ready, output, 1, request accepted when valid and ready are both high.
REQ-006 SHALL have ports muldiv_i_src1 and muldiv_i_src2, input, 64 each, the forwarded operands.
REQ-007 SHALL have port muldiv_i_rd, input, 5, destination register tag.
REQ-008 SHALL have port muldiv_i_flush, input, 1, which aborts any operation.
REQ-009 SHALL have port muldiv_o_valid, output, 1, result available.
REQ-010 SHALL have port muldiv_i_ready, input, 1, downstream accepts the result.
REQ-011 SHALL have port muldiv_o_result, output, 64, the result.
REQ-012 SHALL have port muldiv_o_rd, output, 5, tag of the result.
REQ-013 SHALL have port muldiv_o_busy, output, 1, pipeline stall request; high in any state other than IDLE.

Function
REQ-014 SHALL implement states IDLE, CALC and DONE; muldiv_o_ready = (state == IDLE).
REQ-015 SHALL, in IDLE, on accept with any bit 12..0 set: latch the op, operands and rd, then go to CALC with iteration counter = 0.
REQ-016 SHALL discard an accepted request with bits 12..0 all zero and stay in IDLE.
REQ-017 SHALL select the most significant set bit when several of bits 12..0 are set.
REQ-018 SHALL, for W ops, use low-32-bit operands: sign-extended for mulw/divw/remw, zero-extended for divuw/remuw.
REQ-019 SHALL sign-extend the 32-bit result of every W op from bit 31.
REQ-020 SHALL multiply radix-2 shift-add on operand magnitudes into a 128-bit product, one bit per CALC cycle, then correct the sign.
REQ-021 SHALL treat mulh operands as signed×signed, mulhsu as signed×unsigned and mulhu as unsigned×unsigned.
REQ-022 SHALL return product[63:0] for mul/mulw and product[127:64] for the mulh variants.
REQ-023 SHALL divide by restoring division on magnitudes, one quotient bit per CALC cycle.
REQ-024 SHALL give the quotient the sign of (src1 XOR src2) and the remainder the sign of the dividend.
REQ-025 SHALL run CALC for exactly 64 cycles for 64-bit ops and exactly 32 cycles for W ops, then enter DONE.
REQ-026 SHALL, for divide by zero, give quotient all-ones and remainder equal to the dividend. This case skips CALC: IDLE goes directly to DONE.
REQ-027 SHALL, for signed overflow (most-negative ÷ -1, at op width), give quotient = dividend and remainder = 0, also going directly to DONE.
REQ-028 SHALL assert muldiv_o_valid exactly in DONE, giving first valid N+65 / N+33 / N+1 cycles after accept cycle N for 64-bit / W / special ops.
REQ-029 SHALL hold muldiv_o_result and muldiv_o_rd stable while in DONE with muldiv_i_ready low.
REQ-030 SHALL go from DONE to IDLE on muldiv_i_ready.
REQ-031 SHALL accept a new request no earlier than the cycle after DONE exits.
REQ-032 SHALL, on muldiv_i_flush in any state, go to IDLE at the next edge; muldiv_o_valid is low from that edge on.
REQ-033 SHALL NOT accept a request that arrives in the same cycle as flush.
REQ-034 SHALL give flush priority over muldiv_i_ready in DONE.

Reset
REQ-035 SHALL, when rst is high at an edge, enter IDLE regardless of state, including mid-CALC.
REQ-036 SHALL, after reset, clear the counter and drive muldiv_o_valid=0, muldiv_o_busy=0, muldiv_o_ready=1, muldiv_o_result=0, muldiv_o_rd=0.
REQ-037 SHALL give rst priority over flush and valid.

Verification
REQ-038 SHALL cover mul, src1=7, src2=0xFFFFFFFFFFFFFFFD, rd=5: result 0xFFFFFFFFFFFFFFEB and rd 5, valid 65 cycles after accept.
REQ-039 SHALL cover mulhu with both operands 0xFFFFFFFFFFFFFFFF: result 0xFFFFFFFFFFFFFFFE. Also mulh with the same operands: result 0.
REQ-040 SHALL cover div 100/0: result 0xFFFFFFFFFFFFFFFF. Also rem 100/0: result 0x64. Both valid 1 cycle after accept.
REQ-041 SHALL cover div 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF: result 0x8000000000000000. Also rem with the same operands: result 0. Both valid 1 cycle after accept.
REQ-042 SHALL cover divw with src1=0x00000000FFFFFFF9, src2=2: result 0xFFFFFFFFFFFFFFFD, valid 33 cycles after accept. Also remw with the same operands: result 0xFFFFFFFFFFFFFFFF.
REQ-043 SHALL cover flush at CALC iteration 10: ready high next cycle and valid never asserts. Also hold muldiv_i_ready low 5 cycles in DONE: result stable, then IDLE one cycle after ready rises.

Source files
------------

// File: rtl/execute_muldiv.sv
// Iterative integer multiply/divide unit: radix-2 shift-add multiply and
// restoring divide, one bit per cycle, with divide-by-zero and signed
// overflow resolved at accept time.
module execute_muldiv (
   input  logic        clk,
   input  logic        rst,
   input  logic [27:0] decode_i_alu_info,
   input  logic        muldiv_i_valid,
   output logic        muldiv_o_ready,
   input  logic [63:0] muldiv_i_src1,
   input  logic [63:0] muldiv_i_src2,
   input  logic [4:0]  muldiv_i_rd,
   input  logic        muldiv_i_flush,
   output logic        muldiv_o_valid,
   input  logic        muldiv_i_ready,
   output logic [63:0] muldiv_o_result,
   output logic [4:0]  muldiv_o_rd,
   output logic        muldiv_o_busy
);

   localparam int unsigned XLEN = 64;
   localparam int unsigned CW   = 6;
   localparam logic [XLEN-1:0] MIN_D = 64'h8000_0000_0000_0000;
   localparam logic [XLEN-1:0] MIN_W = 64'hFFFF_FFFF_8000_0000;

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t state, state_nxt;

   // decoded request
   logic d_valid, d_mul, d_hi, d_rem, d_w, d_sa, d_sb;
   logic [XLEN-1:0] a_ext, b_ext, a_mag, b_mag, special_res;
   logic a_neg, b_neg, div_zero, div_ovf, special, start;

   // latched operation and iteration state
   logic            op_mul, op_hi, op_rem, op_w, neg, neg_r;
   logic [CW-1:0]   cnt;
   logic [127:0]    prod, mcand;
   logic [XLEN-1:0] mplier, rem, quo, dvsr;

   // one-iteration next values and final result
   logic [127:0]    prod_nxt, mcand_nxt, prod_fix;
   logic [XLEN-1:0] mplier_nxt, rem_nxt, quo_nxt, quo_fix, rem_fix, raw, calc_res;
   logic [XLEN:0]   div_sh;
   logic            div_ge, calc_last;

   logic unused_alu;
   assign unused_alu = ^decode_i_alu_info[27:13];

   function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

   // Priority decode of the op one-hot: highest set bit wins.
   always_comb begin
      d_valid = 1'b1;
      d_mul   = 1'b0;
      d_hi    = 1'b0;
      d_rem   = 1'b0;
      d_w     = 1'b0;
      d_sa    = 1'b0;
      d_sb    = 1'b0;
      casez (decode_i_alu_info[12:0])
         13'b1????????????: begin d_mul = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
         13'b01???????????: begin d_mul = 1'b1; d_hi = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
         13'b001??????????: begin d_mul = 1'b1; d_hi = 1'b1; d_sa = 1'b1; end
         13'b0001?????????: begin d_mul = 1'b1; d_hi = 1'b1; end
         13'b00001????????: begin d_sa = 1'b1; d_sb = 1'b1; end
         13'b000001???????: ;
         13'b0000001??????: begin d_rem = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
         13'b00000001?????: d_rem = 1'b1;
         13'b000000001????: begin d_mul = 1'b1; d_w = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
         13'b0000000001???: begin d_w = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
         13'b00000000001??: d_w = 1'b1;
         13'b000000000001?: begin d_rem = 1'b1; d_w = 1'b1; d_sa = 1'b1; d_sb = 1'b1; end
         13'b0000000000001: begin d_rem = 1'b1; d_w = 1'b1; end
         default:           d_valid = 1'b0;
      endcase
   end

   // Operand width/sign preparation and special-case detection.
   always_comb begin
      a_ext = muldiv_i_src1;
      b_ext = muldiv_i_src2;
      if (d_w) begin
         a_ext = d_sa ? sext32(muldiv_i_src1[31:0]) : {32'b0, muldiv_i_src1[31:0]};
         b_ext = d_sb ? sext32(muldiv_i_src2[31:0]) : {32'b0, muldiv_i_src2[31:0]};
      end
      a_neg    = d_sa & a_ext[XLEN-1];
      b_neg    = d_sb & b_ext[XLEN-1];
      a_mag    = a_neg ? -a_ext : a_ext;
      b_mag    = b_neg ? -b_ext : b_ext;
      div_zero = ~d_mul & (b_ext == '0);
      div_ovf  = ~d_mul & d_sa & d_sb & (a_ext == (d_w ? MIN_W : MIN_D)) & (b_ext == '1);
      special  = div_zero | div_ovf;
      if (div_zero) special_res = d_rem ? a_ext : '1;
      else          special_res = d_rem ? '0 : a_ext;
      if (d_w) special_res = sext32(special_res[31:0]);
      start = (state == IDLE) & muldiv_i_valid & ~muldiv_i_flush & d_valid;
   end

   // One multiply/divide iteration plus sign correction of the final value.
   always_comb begin
      prod_nxt   = prod + (mplier[0] ? mcand : '0);
      mcand_nxt  = {mcand[126:0], 1'b0};
      mplier_nxt = {1'b0, mplier[XLEN-1:1]};
      div_sh     = {rem, quo[XLEN-1]};
      div_ge     = div_sh >= {1'b0, dvsr};
      rem_nxt    = div_ge ? 64'(div_sh - {1'b0, dvsr}) : div_sh[XLEN-1:0];
      quo_nxt    = {quo[XLEN-2:0], div_ge};
      prod_fix   = neg ? -prod_nxt : prod_nxt;
      quo_fix    = neg ? -quo_nxt : quo_nxt;
      rem_fix    = neg_r ? -rem_nxt : rem_nxt;
      if (op_mul) raw = op_hi ? prod_fix[127:64] : prod_fix[63:0];
      else        raw = op_rem ? rem_fix : quo_fix;
      calc_res   = op_w ? sext32(raw[31:0]) : raw;
      calc_last  = (cnt == (op_w ? 6'd31 : 6'd63));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state and handshake outputs; flush overrides every transition.
   always_comb begin
      state_nxt      = state;
      muldiv_o_ready = (state == IDLE);
      muldiv_o_valid = (state == DONE);
      muldiv_o_busy  = (state != IDLE);
      case (state)
         IDLE:    if (start) state_nxt = special ? DONE : CALC;
         CALC:    if (calc_last) state_nxt = DONE;
         DONE:    if (muldiv_i_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (muldiv_i_flush) state_nxt = IDLE;
   end

   // Datapath: load on accept, iterate in CALC, capture result on last step.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_mul <= 1'b0; op_hi <= 1'b0; op_rem <= 1'b0; op_w <= 1'b0;
         neg <= 1'b0; neg_r <= 1'b0; cnt <= '0;
         prod <= '0; mcand <= '0; mplier <= '0; rem <= '0; quo <= '0; dvsr <= '0;
         muldiv_o_result <= '0;
         muldiv_o_rd     <= '0;
      end else if (start) begin
         op_mul <= d_mul; op_hi <= d_hi; op_rem <= d_rem; op_w <= d_w;
         neg    <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         cnt    <= '0;
         prod   <= '0;
         mcand  <= {64'b0, a_mag};
         mplier <= b_mag;
         rem    <= '0;
         quo    <= d_w ? {a_mag[31:0], 32'b0} : a_mag;
         dvsr   <= b_mag;
         muldiv_o_rd <= muldiv_i_rd;
         if (special) muldiv_o_result <= special_res;
      end else if (state == CALC) begin
         cnt    <= cnt + 6'd1;
         prod   <= prod_nxt;
         mcand  <= mcand_nxt;
         mplier <= mplier_nxt;
         rem    <= rem_nxt;
         quo    <= quo_nxt;
         if (calc_last) muldiv_o_result <= calc_res;
      end
   end

endmodule
